// File: rtl/cal_pkg.sv
// Shared types and helpers for the N-point calibration interpolator.
package cal_pkg;

  typedef enum logic [2:0] {IDLE, CHECK, SEARCH, DIV, DONE} state_t;

  localparam logic [1:0] PMD_2   = 2'd0;
  localparam logic [1:0] PMD_3   = 2'd1;
  localparam logic [1:0] PMD_5   = 2'd2;
  localparam logic [1:0] PMD_MAX = 2'd3;

  // Active point count selected by point_md, never more than the table holds.
  function automatic int pts_from_md(input logic [1:0] md, input int max_pts);
    int n;
    case (md)
      PMD_2:   n = 2;
      PMD_3:   n = 3;
      PMD_5:   n = (max_pts < 5) ? max_pts : 5;
      default: n = max_pts;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/cal_interp_np_if.sv
// Configuration, request and result signals of the calibration interpolator.
interface cal_interp_np_if #(
  parameter int MAX_PTS = 8,
  parameter int PT_W    = 16,
  parameter int FRAC_W  = 8
);
  localparam int IW = $clog2(MAX_PTS);

  logic                 cfg_wen;
  logic [IW:0]          cfg_addr;
  logic [7:0]           cfg_wdata;
  logic [1:0]           point_md;
  logic                 mic_mode;
  logic                 start;
  logic [PT_W-1:0]      raw;
  logic                 busy;
  logic                 res_valid;
  logic [IW+FRAC_W-1:0] result;
  logic                 sat_lo;
  logic                 sat_hi;
  logic                 tbl_err;
  logic                 wr_drop;

  modport master (
    output cfg_wen, cfg_addr, cfg_wdata, point_md, mic_mode, start, raw,
    input  busy, res_valid, result, sat_lo, sat_hi, tbl_err, wr_drop
  );

  modport slave (
    input  cfg_wen, cfg_addr, cfg_wdata, point_md, mic_mode, start, raw,
    output busy, res_valid, result, sat_lo, sat_hi, tbl_err, wr_drop
  );

endinterface

// File: rtl/cal_div_seq.sv
// Restoring divider for (num << FRAC_W) / den with num < den, one quotient bit per clock.
module cal_div_seq #(
  parameter int PT_W   = 16,
  parameter int FRAC_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [PT_W-1:0]   num,
  input  logic [PT_W-1:0]   den,
  output logic              done,
  output logic [FRAC_W-1:0] quo
);
  localparam int CW = $clog2(FRAC_W + 1);

  logic [PT_W-1:0] rem;
  logic [PT_W-1:0] den_r;
  logic [CW-1:0]   cnt;
  logic [PT_W:0]   shifted;
  logic            ge;

  // done marks the cycle whose closing edge produces the last quotient bit.
  always_comb begin
    shifted = {rem, 1'b0};
    ge      = shifted >= {1'b0, den_r};
    done    = (cnt == CW'(1));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rem   <= '0;
      den_r <= '0;
      cnt   <= '0;
      quo   <= '0;
    end else if (load) begin
      rem   <= num;
      den_r <= den;
      cnt   <= CW'(FRAC_W);
      quo   <= '0;
    end else if (cnt != '0) begin
      rem   <= ge ? PT_W'(shifted - {1'b0, den_r}) : PT_W'(shifted);
      quo   <= {quo[FRAC_W-2:0], ge};
      cnt   <= cnt - 1'b1;
    end
  end

endmodule

// File: rtl/cal_interp_np.sv
// N-point piecewise-linear calibration: clamp/order check, linear segment search,
// then a fractional divide inside the found segment.
module cal_interp_np
  import cal_pkg::*;
#(
  parameter int MAX_PTS = 8,
  parameter int PT_W    = 16,
  parameter int FRAC_W  = 8
) (
  input logic         clk,
  input logic         rst,
  cal_interp_np_if.slave bus
);
  localparam int IW = $clog2(MAX_PTS);
  localparam int RW = IW + FRAC_W;

  state_t            state;
  logic [PT_W-1:0]   tbl [MAX_PTS];
  logic [PT_W-1:0]   raw_sh;
  logic [IW:0]       n_sh;
  logic              mode_sh;
  logic [IW-1:0]     idx;
  logic [IW-1:0]     seg;
  logic              err_r;
  logic              lo_r;
  logic              hi_r;

  logic [IW-1:0]     last_idx;
  logic              order_bad;
  logic              below;
  logic              above;
  logic              hit;
  logic [PT_W-1:0]   num;
  logic [PT_W-1:0]   den;
  logic              div_load;
  logic              div_done;
  logic [FRAC_W-1:0] quo;
  logic [RW-1:0]     full_scale;
  logic [RW-1:0]     q_val;
  logic [RW-1:0]     res_nxt;

  always_comb begin
    order_bad = 1'b0;
    for (int i = 1; i < MAX_PTS; i++) begin
      if (i < int'(n_sh) && tbl[IW'(i)] <= tbl[IW'(i - 1)]) order_bad = 1'b1;
    end
    last_idx   = IW'(n_sh - 1'b1);
    below      = raw_sh < tbl[0];
    above      = raw_sh >= tbl[last_idx];
    hit        = raw_sh < tbl[idx];
    num        = raw_sh - tbl[idx - 1'b1];
    den        = tbl[idx] - tbl[idx - 1'b1];
    div_load   = (state == SEARCH) && hit;
    full_scale = RW'(n_sh - 1'b1) << FRAC_W;
    // Clamp flags always describe the raw count; inversion only touches the level.
    q_val      = hi_r ? full_scale : (lo_r ? '0 : {seg, quo});
    res_nxt    = err_r ? '0 : (mode_sh ? full_scale - q_val : q_val);
  end

  cal_div_seq #(
    .PT_W   (PT_W),
    .FRAC_W (FRAC_W)
  ) u_div (
    .clk  (clk),
    .rst  (rst),
    .load (div_load),
    .num  (num),
    .den  (den),
    .done (div_done),
    .quo  (quo)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      for (int i = 0; i < MAX_PTS; i++) tbl[i] <= '0;
      raw_sh        <= '0;
      n_sh          <= '0;
      mode_sh       <= 1'b0;
      idx           <= '0;
      seg           <= '0;
      err_r         <= 1'b0;
      lo_r          <= 1'b0;
      hi_r          <= 1'b0;
      bus.busy      <= 1'b0;
      bus.res_valid <= 1'b0;
      bus.result    <= '0;
      bus.sat_lo    <= 1'b0;
      bus.sat_hi    <= 1'b0;
      bus.tbl_err   <= 1'b0;
      bus.wr_drop   <= 1'b0;
    end else begin
      bus.res_valid <= 1'b0;
      if (bus.cfg_wen) begin
        if (state != IDLE) begin
          bus.wr_drop <= 1'b1;
        end else if (bus.cfg_addr[0]) begin
          tbl[bus.cfg_addr[IW:1]][PT_W-1:8] <= bus.cfg_wdata[PT_W-9:0];
        end else begin
          tbl[bus.cfg_addr[IW:1]][7:0] <= bus.cfg_wdata;
        end
      end
      case (state)
        IDLE: begin
          if (bus.start) begin
            raw_sh   <= bus.raw;
            n_sh     <= (IW+1)'(pts_from_md(bus.point_md, MAX_PTS));
            mode_sh  <= bus.mic_mode;
            bus.busy <= 1'b1;
            state    <= CHECK;
          end
        end
        CHECK: begin
          idx   <= IW'(1);
          err_r <= order_bad;
          lo_r  <= !order_bad && below;
          hi_r  <= !order_bad && !below && above;
          state <= (order_bad || below || above) ? DONE : SEARCH;
        end
        SEARCH: begin
          if (hit) begin
            seg   <= idx - 1'b1;
            state <= DIV;
          end else begin
            idx   <= idx + 1'b1;
          end
        end
        DIV: begin
          if (div_done) state <= DONE;
        end
        DONE: begin
          bus.result    <= res_nxt;
          bus.sat_lo    <= lo_r;
          bus.sat_hi    <= hi_r;
          bus.tbl_err   <= err_r;
          bus.res_valid <= 1'b1;
          bus.busy      <= 1'b0;
          state         <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
